sram_read_arbiter: RTL and testbench

Shares the single read-only SRAM port (the `sram_controller` read sequencer) between several fetch clients: background/menu draw, sprite fetch, and spare. Grants are round-robin. The arbiter launches one controller read per grant and holds the address stable for the whole access. It returns the 16-bit word to the granted client with a one-cycle response pulse, and waits for the controller to return to idle before the next grant. A watchdog guarantees a response even if `done_r` never arrives.

---
 rtl/sram_read_arbiter_pkg.sv | 23 ++
 rtl/sram_read_arbiter_if.sv | 46 ++++
 rtl/sram_read_arbiter_rr_pick.sv | 37 +++
 rtl/sram_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_read_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tron_sram_pkg
// Shared types and constants for the SRAM read-side arbitration logic.
//   SRAM_AW       : word address width of the SRAM controller port
//   SRAM_DW       : data width of one SRAM word
//   TIMEOUT_DATA  : word returned to a client when its access times out
//   arb_state_t   : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package tron_sram_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    localparam logic [SRAM_DW-1:0] TIMEOUT_DATA = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter_if
// Bundles the client request/response bus and the controller read port of the
// SRAM read arbiter.
//   req / req_addr        : per-client level request + word address
//   rsp_valid / rsp_data  : one-hot response pulse + returned word
//   rsp_err               : response came from the watchdog, not the SRAM
//   busy                  : arbiter is in any state other than IDLE
//   mem_read / mem_addr   : controller Read strobe and addr_in
//   mem_done / mem_data   : controller done_r and OUTPUT_DATA
// Modports:
//   slave  : the arbiter itself
//   master : the environment (clients + SRAM controller)
//
// Handshake: a client raises req[i] with a stable req_addr[i] and holds both
// until it sees rsp_valid[i] for one cycle; it must drop or change req[i] the
// cycle after. The arbiter raises mem_read for exactly one cycle per access
// with mem_addr already stable, and accepts mem_data in the cycle mem_done=1.
// ---------------------------------------------------------------------------
interface sram_read_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import tron_sram_pkg::*;

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0][SRAM_AW-1:0] req_addr;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [SRAM_DW-1:0]              rsp_data;
    logic                            rsp_err;
    logic                            busy;
    logic                            mem_read;
    logic [SRAM_AW-1:0]              mem_addr;
    logic                            mem_done;
    logic [SRAM_DW-1:0]              mem_data;

    modport slave (
        input  req, req_addr, mem_done, mem_data,
        output rsp_valid, rsp_data, rsp_err, busy, mem_read, mem_addr
    );

    modport master (
        output req, req_addr, mem_done, mem_data,
        input  rsp_valid, rsp_data, rsp_err, busy, mem_read, mem_addr
    );

endinterface

// File: rtl/sram_read_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after rr_ptr_i, scanning upward and wrapping at NUM_REQ.
//   req_i      : request vector
//   rr_ptr_i   : index with highest priority this round (0..NUM_REQ-1)
//   grant_id_o : index of the selected requester (0 when none)
//   any_o      : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      rr_ptr_i,
    output logic [GW-1:0]      grant_id_o,
    output logic               any_o
);

    always_comb begin
        grant_id_o = '0;
        any_o      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            // First hit wins; later offsets are lower priority.
            if (!any_o && req_i[GW'(idx)]) begin
                any_o      = 1'b1;
                grant_id_o = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter
// Shares the single read-only SRAM controller port between NUM_REQ fetch
// clients with round-robin grants. One controller read per grant; the address
// is held from grant until the next grant. The word returns to the granted
// client with a one-cycle rsp_valid pulse. The arbiter waits for the
// controller to drop done before re-arbitrating, and a watchdog bounds both
// the wait for done (error response) and the wait for done to clear.
// Ports:
//   Clk, Reset  : clock, synchronous active-high reset
//   bus         : sram_read_arbiter_if.slave (client and controller signals)
//   dbg_state_o : current FSM state, for observation only
// ---------------------------------------------------------------------------
module sram_read_arbiter
    import tron_sram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_read_arbiter_if.slave    bus,
    output arb_state_t            dbg_state_o
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_t             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic                   mem_read_q, mem_read_d;
    logic [SRAM_AW-1:0]     mem_addr_q, mem_addr_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [SRAM_DW-1:0]     rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [GW-1:0]          pick_id;
    logic                   pick_any;
    logic [WW-1:0]          wd_inc;
    logic                   wd_expired;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i      (bus.req),
        .rr_ptr_i   (rr_ptr_q),
        .grant_id_o (pick_id),
        .any_o      (pick_any)
    );

    // The watchdog counts cycles spent in WAIT or DRAIN; it expires on the
    // cycle its count would reach TIMEOUT, i.e. the TIMEOUT-th cycle there.
    assign wd_inc     = wd_q + 1'b1;
    assign wd_expired = (wd_inc == WW'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wd_d        = wd_q;
        mem_read_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_id;
                    mem_addr_d = bus.req_addr[pick_id];
                    // Registered, so Read is high during ISSUE only.
                    mem_read_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_done) begin
                    rsp_data_d           = bus.mem_data;
                    rsp_err_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    wd_d                 = '0;
                    state_d              = DRAIN;
                end else if (wd_expired) begin
                    rsp_data_d           = TIMEOUT_DATA;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    wd_d                 = '0;
                    state_d              = DRAIN;
                end else begin
                    wd_d = wd_inc;
                end
            end
            DRAIN: begin
                // Do not re-arbitrate until the controller has left done,
                // otherwise the next Read would be missed by the controller.
                if (!bus.mem_done || wd_expired) begin
                    rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    wd_d     = '0;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            wd_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wd_q        <= wd_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_read_arbiter
// Directed bench for sram_read_arbiter (NUM_REQ=3, TIMEOUT=15). Inputs are
// driven and outputs sampled on the falling edge; "cycle t" is the cycle in
// which a request is first presented while the arbiter is IDLE.
// A behavioural SRAM controller raises done for two cycles, three and four
// cycles after it samples Read, and can be told to never raise done (hang)
// or to hold done high (stuck).
// ---------------------------------------------------------------------------
module tb_sram_read_arbiter;
    import tron_sram_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int TIMEOUT = 15;

    localparam logic [SRAM_AW-1:0] A0 = 20'h01234;
    localparam logic [SRAM_AW-1:0] A1 = 20'h00100;
    localparam logic [SRAM_AW-1:0] A2 = 20'h0ABCD;
    // Hand-computed words returned by the SRAM model for A0, A1, A2.
    localparam logic [SRAM_DW-1:0] D0 = 16'h486E;  // 16'h1234 ^ 16'h5A5A
    localparam logic [SRAM_DW-1:0] D1 = 16'hBEEF;
    localparam logic [SRAM_DW-1:0] D2 = 16'hF197;  // 16'hABCD ^ 16'h5A5A

    logic       Clk;
    logic       Reset;
    arb_state_t dbg_state;

    sram_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    sram_read_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- SRAM controller model ----------------
    int                 ph = 0;
    logic [SRAM_AW-1:0] m_addr = '0;
    bit                 hang = 1'b0;
    bit                 stuck = 1'b0;
    int                 overlap = 0;

    function automatic logic [SRAM_DW-1:0] mem_word(input logic [SRAM_AW-1:0] a);
        if (a == 20'h00100) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            ph <= 0;
        end else begin
            if (bus.mem_read && ph != 0) overlap <= overlap + 1;
            if (ph == 0) begin
                if (bus.mem_read) begin
                    ph     <= 1;
                    m_addr <= bus.mem_addr;
                end
            end else if (ph == 4) begin
                if (!stuck) ph <= 0;
            end else begin
                ph <= ph + 1;
            end
        end
    end

    assign bus.mem_done = !hang && (ph == 3 || ph == 4);
    assign bus.mem_data = mem_word(m_addr);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     32'(dbg_state),     32'(IDLE));
        check({tag, "_mem_read"},  32'(bus.mem_read),  32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [SRAM_DW-1:0] rr_data [3];
    logic [NUM_REQ-1:0] rr_vec  [3];

    initial begin
        rr_data[0] = D0; rr_data[1] = D1; rr_data[2] = D2;
        rr_vec[0]  = 3'b001; rr_vec[1] = 3'b010; rr_vec[2] = 3'b100;

        Reset = 1'b1;
        bus.req = '0;
        bus.req_addr[0] = A0;
        bus.req_addr[1] = A1;
        bus.req_addr[2] = A2;
        step(2);
        check_reset_values("reset");
        Reset = 1'b0;
        step(1);

        // ---- single request from client 1 ----
        bus.req = 3'b010;                                          // t
        step(1);                                                   // t+1
        check("single_issue_state", 32'(dbg_state), 32'(ISSUE));
        check("single_mem_read",    32'(bus.mem_read), 32'd1);
        check("single_mem_addr",    32'(bus.mem_addr), 32'(A1));
        check("single_busy",        32'(bus.busy), 32'd1);
        step(1);                                                   // t+2
        check("single_read_drop",   32'(bus.mem_read), 32'd0);
        step(2);                                                   // t+4
        check("single_no_early",    32'(bus.rsp_valid), 32'd0);
        step(1);                                                   // t+5
        check("single_rsp_valid",   32'(bus.rsp_valid), 32'b010);
        check("single_rsp_data",    32'(bus.rsp_data), 32'(D1));
        check("single_rsp_err",     32'(bus.rsp_err), 32'd0);
        bus.req = '0;
        step(1);                                                   // t+6
        check("single_pulse_end",   32'(bus.rsp_valid), 32'd0);
        check("single_drain",       32'(dbg_state), 32'(DRAIN));
        step(1);                                                   // t+7
        check("single_idle",        32'(dbg_state), 32'(IDLE));
        check("single_data_hold",   32'(bus.rsp_data), 32'(D1));

        // ---- all three requesting: grants 0,1,2,0 every 7 cycles ----
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        bus.req = 3'b111;                                          // t
        for (int k = 0; k < 4; k++) begin
            step(k == 0 ? 4 : 6);
            check("rr_gap", 32'(bus.rsp_valid), 32'd0);
            step(1);                                               // t+5+7k
            check("rr_valid", 32'(bus.rsp_valid), 32'(rr_vec[k % 3]));
            check("rr_data",  32'(bus.rsp_data),  32'(rr_data[k % 3]));
        end
        bus.req = '0;
        step(2);
        check("rr_idle", 32'(dbg_state), 32'(IDLE));

        // ---- pointer wrap: grant 2, then 3'b101 -> 0 then 2 ----
        bus.req = 3'b100;                                          // t
        step(5);
        check("wrap_g2_valid", 32'(bus.rsp_valid), 32'b100);
        check("wrap_g2_data",  32'(bus.rsp_data),  32'(D2));
        bus.req = 3'b101;
        step(7);
        check("wrap_g0_valid", 32'(bus.rsp_valid), 32'b001);
        check("wrap_g0_data",  32'(bus.rsp_data),  32'(D0));
        bus.req = 3'b100;
        step(7);
        check("wrap_g2b_valid", 32'(bus.rsp_valid), 32'b100);
        bus.req = '0;
        step(2);

        // ---- timeout: done never arrives ----
        hang = 1'b1;
        bus.req = 3'b001;                                          // t
        step(16);                                                  // t+16
        check("to_no_early", 32'(bus.rsp_valid), 32'd0);
        check("to_waiting",  32'(dbg_state), 32'(WAIT));
        step(1);                                                   // t+17
        check("to_valid", 32'(bus.rsp_valid), 32'b001);
        check("to_err",   32'(bus.rsp_err),   32'd1);
        check("to_data",  32'(bus.rsp_data),  32'(TIMEOUT_DATA));
        bus.req = '0;
        step(1);                                                   // t+18
        check("to_idle",     32'(dbg_state), 32'(IDLE));
        check("to_err_hold", 32'(bus.rsp_err), 32'd1);
        hang = 1'b0;
        bus.req = 3'b010;
        step(5);
        check("to_next_valid", 32'(bus.rsp_valid), 32'b010);
        check("to_next_data",  32'(bus.rsp_data),  32'(D1));
        check("to_next_err",   32'(bus.rsp_err),   32'd0);
        bus.req = '0;
        step(2);

        // ---- reset while in WAIT ----
        bus.req = 3'b001;                                          // t
        step(3);                                                   // t+3
        check("rst_in_wait", 32'(dbg_state), 32'(WAIT));
        Reset = 1'b1;
        bus.req = '0;
        step(1);                                                   // t+4
        check_reset_values("rst_mid");
        Reset = 1'b0;
        bus.req = 3'b001;                                          // t'
        step(1);
        check("rst_after_read", 32'(bus.mem_read), 32'd1);
        check("rst_after_addr", 32'(bus.mem_addr), 32'(A0));
        step(4);                                                   // t'+5
        check("rst_after_valid", 32'(bus.rsp_valid), 32'b001);
        check("rst_after_data",  32'(bus.rsp_data),  32'(D0));
        bus.req = '0;
        step(2);

        // ---- stuck done: DRAIN leaves only on watchdog ----
        stuck = 1'b1;
        bus.req = 3'b010;                                          // t
        step(5);                                                   // t+5
        check("stuck_valid", 32'(bus.rsp_valid), 32'b010);
        check("stuck_data",  32'(bus.rsp_data),  32'(D1));
        bus.req = 3'b001;
        for (int i = 6; i <= 19; i++) begin
            step(1);
            check("stuck_no_read", 32'(bus.mem_read), 32'd0);
        end
        check("stuck_drain_last", 32'(dbg_state), 32'(DRAIN));
        step(1);                                                   // t+20
        check("stuck_idle", 32'(dbg_state), 32'(IDLE));
        stuck = 1'b0;
        step(1);                                                   // t+21
        check("stuck_next_read", 32'(bus.mem_read), 32'd1);
        check("stuck_next_addr", 32'(bus.mem_addr), 32'(A0));
        step(4);                                                   // t+25
        check("stuck_next_valid", 32'(bus.rsp_valid), 32'b001);
        check("stuck_next_data",  32'(bus.rsp_data),  32'(D0));
        bus.req = '0;
        step(2);

        check("no_read_while_ctrl_busy", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
